knn_vote: RTL and testbench
===========================

# knn_vote

Majority-vote classifier stage placed directly downstream of the KNN sorter. It consumes the K nearest-neighbour labels that the sorter emits, nearest first. It counts votes per class and returns the winning class label together with its vote count. Ties are broken in favour of the class whose first vote came from the nearer neighbour.

## Interface
- K, 10, number of neighbour labels per vote (≥1)
- N_CLASSES, 10, number of valid classes; labels 0..N_CLASSES-1
- LABEL_W, 4, label width (2^LABEL_W ≥ N_CLASSES)
- Derived: CNT_W = clog2(K+1), IDX_W = clog2(K) (min 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: clear counters, begin new vote
- lbl_valid  in  1  label valid
- lbl_ready  out  1  block accepts label
- lbl  in  LABEL_W  neighbour label
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_label  out  LABEL_W  winning class
- res_votes  out  CNT_W  votes of winning class
- busy  out  1  high in ACCUM or SCAN
- err  out  1  sticky: an out-of-range label was received since last start

## Operation
- States: IDLE, ACCUM, SCAN, DONE. Reset → IDLE.
- start has priority in every state. It zeroes all counters, first-index regs, err, the accept index and the scan regs, and enters ACCUM on the same edge.
- ACCUM: lbl_ready=1. On each lbl_valid&lbl_ready edge, idx increments.
  - If lbl < N_CLASSES: cnt[lbl]++. If cnt[lbl] was 0, first[lbl]=idx.
  - Otherwise: the label is accepted but not counted, and err is set.
  - After the K-th accept: → SCAN, with scan index 0, best_cnt=0, best_first=all-ones, best_label=0.
- SCAN: one class per cycle, i = 0..N_CLASSES-1. Class i replaces best if cnt[i]>best_cnt, or if cnt[i]==best_cnt, cnt[i]≠0 and first[i]<best_first. After class N_CLASSES-1: → DONE, res_label=best_label, res_votes=best_cnt.
- DONE: res_valid=1. Result is held stable until res_valid&res_ready, then → IDLE.
- All labels out of range: result is label 0, votes 0, err=1.
- Counters cannot overflow (max K, width CNT_W). Votes are unsigned.

## Timing
- Reset values: lbl_ready=0, res_valid=0, res_label=0, res_votes=0, busy=0, err=0.
- lbl_ready and res_valid are registered state decodes with no combinational path from lbl_valid or res_ready.
- One label per cycle at full throughput. K accepts take exactly K cycles if lbl_valid is held high.
- res_valid rises N_CLASSES edges after the edge that accepts the K-th label.
- lbl_ready=0 in IDLE, SCAN and DONE. Labels presented then are not consumed.
- start in the same cycle as a lbl_valid handshake: start wins and the label is not counted.
- start in DONE discards the pending result.
- Reset mid-operation returns all outputs to reset values asynchronously.
- err persists through DONE and IDLE until the next start.

## Test plan
- K=10, N=10. Labels 3,3,5,3,1,5,5,5,2,3 streamed back-to-back → classes 3 and 5 tie at 4 votes. Required: res_label=3, res_votes=4, res_valid 10 edges after the last accept, err=0.
- Ten labels of 7 → res_label=7, res_votes=10. Then with res_ready low for 5 cycles: res_valid and data are held, lbl_ready=0. The result drops one cycle after res_ready=1.
- Labels 12,2,2,9,12,9,9,0,1,4 → err=1. 12 is not counted; res_label=9, res_votes=3.
- start, 4 labels of 6, start again, then 1,1,1,2,2,2,2,0,0,0 → res_label=2, res_votes=4. The 6s are absent (res_label≠6).
- Assert rst during SCAN → all outputs at reset values immediately. After release, start plus ten labels of 0 → res_label=0, res_votes=10.
- lbl_valid toggling 1-0-1 with ten 4s → exactly 10 accepts. res_votes=10; busy is high from the edge after start until DONE.

Source files
------------

// File: rtl/knn_vote_if.sv
// Handshake bundle between the KNN sorter, the vote stage and the result consumer.
// The master drives labels and accepts results; the slave is the vote stage.
interface knn_vote_if #(
    parameter int LABEL_W = 4,
    parameter int CNT_W   = 4
);
    logic               start;
    logic               lbl_valid;
    logic               lbl_ready;
    logic [LABEL_W-1:0] lbl;
    logic               res_valid;
    logic               res_ready;
    logic [LABEL_W-1:0] res_label;
    logic [CNT_W-1:0]   res_votes;
    logic               busy;
    logic               err;

    modport master (
        output start, lbl_valid, lbl, res_ready,
        input  lbl_ready, res_valid, res_label, res_votes, busy, err
    );

    modport slave (
        input  start, lbl_valid, lbl, res_ready,
        output lbl_ready, res_valid, res_label, res_votes, busy, err
    );
endinterface

// File: rtl/knn_vote.sv
// Majority vote over the K nearest-neighbour labels. A tie goes to the class whose
// first vote arrived earliest, because labels arrive nearest first.
module knn_vote #(
    parameter int K         = 10,
    parameter int N_CLASSES = 10,
    parameter int LABEL_W   = 4,
    parameter int CNT_W     = $clog2(K + 1),
    parameter int IDX_W     = (K > 1) ? $clog2(K) : 1
) (
    input  logic      clk,
    input  logic      rst_n,
    knn_vote_if.slave bus
);
    localparam int SCAN_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt   [N_CLASSES];
    logic [IDX_W-1:0]   r_first [N_CLASSES];
    logic [IDX_W-1:0]   r_idx;
    logic [SCAN_W-1:0]  r_scan;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [IDX_W-1:0]   r_best_first;
    logic [LABEL_W-1:0] r_best_label;
    logic [LABEL_W-1:0] r_res_label;
    logic [CNT_W-1:0]   r_res_votes;
    logic               r_err;

    logic               w_accept;
    logic               w_last_accept;
    logic               w_last_class;
    logic               w_in_range;
    logic [CNT_W-1:0]   w_scan_cnt;
    logic [IDX_W-1:0]   w_scan_first;
    logic [LABEL_W-1:0] w_scan_label;
    logic               w_take;
    logic               w_lbl_ready;
    logic               w_res_valid;
    logic               w_busy;

    // start overrides a simultaneous handshake, so that label is never counted
    assign w_accept      = (r_state == S_ACCUM) && bus.lbl_valid && !bus.start;
    assign w_last_accept = w_accept && (int'(r_idx) == K - 1);
    assign w_last_class  = (int'(r_scan) == N_CLASSES - 1);
    assign w_in_range    = (int'(bus.lbl) < N_CLASSES);
    assign w_scan_cnt    = r_cnt[r_scan];
    assign w_scan_first  = r_first[r_scan];
    assign w_scan_label  = LABEL_W'(r_scan);
    assign w_take        = (w_scan_cnt > r_best_cnt) ||
                           ((w_scan_cnt == r_best_cnt) && (w_scan_cnt != {CNT_W{1'b0}}) &&
                            (w_scan_first < r_best_first));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (bus.start) begin
            w_next_state = S_ACCUM;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_ACCUM: w_next_state = w_last_accept ? S_SCAN : S_ACCUM;
                S_SCAN:  w_next_state = w_last_class ? S_DONE : S_SCAN;
                S_DONE:  w_next_state = bus.res_ready ? S_IDLE : S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output decode of the state register only, never of the handshake inputs
    always_comb begin
        w_lbl_ready = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_ACCUM: begin
                w_lbl_ready = 1'b1;
                w_busy      = 1'b1;
            end
            S_SCAN:  w_busy      = 1'b1;
            S_DONE:  w_res_valid = 1'b1;
            default: w_busy      = 1'b0;
        endcase
    end

    // Vote counters, first-arrival indices, scan tracker and held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                r_cnt[i]   <= {CNT_W{1'b0}};
                r_first[i] <= {IDX_W{1'b0}};
            end
            r_idx        <= {IDX_W{1'b0}};
            r_scan       <= {SCAN_W{1'b0}};
            r_best_cnt   <= {CNT_W{1'b0}};
            r_best_first <= {IDX_W{1'b1}};
            r_best_label <= {LABEL_W{1'b0}};
            r_res_label  <= {LABEL_W{1'b0}};
            r_res_votes  <= {CNT_W{1'b0}};
            r_err        <= 1'b0;
        end else if (bus.start) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                r_cnt[i]   <= {CNT_W{1'b0}};
                r_first[i] <= {IDX_W{1'b0}};
            end
            r_idx        <= {IDX_W{1'b0}};
            r_scan       <= {SCAN_W{1'b0}};
            r_best_cnt   <= {CNT_W{1'b0}};
            r_best_first <= {IDX_W{1'b1}};
            r_best_label <= {LABEL_W{1'b0}};
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= r_idx + 1'b1;
                if (w_in_range) begin
                    r_cnt[bus.lbl] <= r_cnt[bus.lbl] + 1'b1;
                    if (r_cnt[bus.lbl] == {CNT_W{1'b0}}) begin
                        r_first[bus.lbl] <= r_idx;
                    end
                end else begin
                    r_err <= 1'b1;
                end
                if (w_last_accept) begin
                    r_scan       <= {SCAN_W{1'b0}};
                    r_best_cnt   <= {CNT_W{1'b0}};
                    r_best_first <= {IDX_W{1'b1}};
                    r_best_label <= {LABEL_W{1'b0}};
                end
            end
            if (r_state == S_SCAN) begin
                r_scan <= r_scan + 1'b1;
                if (w_take) begin
                    r_best_cnt   <= w_scan_cnt;
                    r_best_first <= w_scan_first;
                    r_best_label <= w_scan_label;
                end
                // The last class's decision lands directly in the result registers
                if (w_last_class) begin
                    r_res_label <= w_take ? w_scan_label : r_best_label;
                    r_res_votes <= w_take ? w_scan_cnt : r_best_cnt;
                end
            end
        end
    end

    assign bus.lbl_ready = w_lbl_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.busy      = w_busy;
    assign bus.res_label = r_res_label;
    assign bus.res_votes = r_res_votes;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote with K=10, ten classes; expected results are hand-computed.
module tb_knn_vote;
    localparam int K  = 10;
    localparam int NC = 10;
    localparam int LW = 4;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_cnt = 0;

    always #5 clk = ~clk;

    knn_vote_if #(.LABEL_W(LW), .CNT_W(CW)) vif ();

    knn_vote #(.K(K), .N_CLASSES(NC), .LABEL_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    // Independent count of label handshakes the DUT should have consumed
    always @(posedge clk) begin
        if (vif.lbl_valid && vif.lbl_ready && !vif.start) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        vif.start = 1'b1;
        tick();
        vif.start = 1'b0;
    endtask

    task automatic send(input logic [3:0] v[10], input bit gap);
        for (int i = 0; i < 10; i++) begin
            if (gap && i > 0) begin
                vif.lbl_valid = 1'b0;
                tick();
                check("busy_gap", 32'(vif.busy), 32'd1);
            end
            vif.lbl_valid = 1'b1;
            vif.lbl       = v[i];
            tick();
            check("busy_accum", 32'(vif.busy), 32'd1);
        end
        vif.lbl_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (!vif.res_valid && n < 60) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(NC));
    endtask

    task automatic expect_res(input string tag, input int lbl_e, input int votes_e, input int err_e);
        check({tag, "_label"}, 32'(vif.res_label), 32'(lbl_e));
        check({tag, "_votes"}, 32'(vif.res_votes), 32'(votes_e));
        check({tag, "_err"},   32'(vif.err),       32'(err_e));
        check({tag, "_busy"},  32'(vif.busy),      32'd0);
    endtask

    task automatic consume(input string tag);
        vif.res_ready = 1'b1;
        tick();
        vif.res_ready = 1'b0;
        check(tag, 32'(vif.res_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   32'(vif.lbl_ready), 32'd0);
        check({tag, "_vld"},   32'(vif.res_valid), 32'd0);
        check({tag, "_label"}, 32'(vif.res_label), 32'd0);
        check({tag, "_votes"}, 32'(vif.res_votes), 32'd0);
        check({tag, "_busy"},  32'(vif.busy),      32'd0);
        check({tag, "_err"},   32'(vif.err),       32'd0);
    endtask

    initial begin
        logic [3:0] v[10];
        int a0;

        vif.start     = 1'b0;
        vif.lbl_valid = 1'b0;
        vif.lbl       = 4'd0;
        vif.res_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Tie between 3 and 5 at four votes; 3 voted first
        do_start();
        check("t1_ready", 32'(vif.lbl_ready), 32'd1);
        v = '{4'd3, 4'd3, 4'd5, 4'd3, 4'd1, 4'd5, 4'd5, 4'd5, 4'd2, 4'd3};
        send(v, 1'b0);
        wait_res("t1_latency");
        expect_res("t1", 3, 4, 0);
        consume("t1_drop");

        // Unanimous 7, then back-pressure for five cycles with a label offered
        do_start();
        v = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7};
        send(v, 1'b0);
        wait_res("t2_latency");
        expect_res("t2", 7, 10, 0);
        a0 = acc_cnt;
        vif.lbl_valid = 1'b1;
        vif.lbl       = 4'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_vld",   32'(vif.res_valid), 32'd1);
            check("t2_hold_label", 32'(vif.res_label), 32'd7);
            check("t2_hold_votes", 32'(vif.res_votes), 32'd10);
            check("t2_hold_rdy",   32'(vif.lbl_ready), 32'd0);
        end
        check("t2_no_accept", 32'(acc_cnt - a0), 32'd0);
        vif.lbl_valid = 1'b0;
        consume("t2_drop");

        // Out-of-range 12 sets err and is not counted
        do_start();
        v = '{4'd12, 4'd2, 4'd2, 4'd9, 4'd12, 4'd9, 4'd9, 4'd0, 4'd1, 4'd4};
        send(v, 1'b0);
        wait_res("t3_latency");
        expect_res("t3", 9, 3, 1);
        consume("t3_drop");
        check("t3_err_idle", 32'(vif.err), 32'd1);

        // Restart mid-vote; the restart cycle also carries a 6 that must be dropped
        do_start();
        check("t4_err_clr", 32'(vif.err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            vif.lbl_valid = 1'b1;
            vif.lbl       = 4'd6;
            tick();
        end
        do_start();
        v = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0};
        send(v, 1'b0);
        wait_res("t4_latency");
        expect_res("t4", 2, 4, 0);
        check("t4_not6", 32'(vif.res_label != 4'd6), 32'd1);
        consume("t4_drop");

        // Asynchronous reset during SCAN, with err and a stale result present
        do_start();
        v = '{4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13};
        send(v, 1'b0);
        tick();
        tick();
        check("t5_in_scan_err", 32'(vif.err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        send(v, 1'b0);
        wait_res("t5_latency");
        expect_res("t5", 0, 10, 0);
        consume("t5_drop");

        // Gapped valid: exactly ten accepts, busy high throughout
        a0 = acc_cnt;
        do_start();
        check("t6_busy_start", 32'(vif.busy), 32'd1);
        v = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
        send(v, 1'b1);
        wait_res("t6_latency");
        check("t6_accepts", 32'(acc_cnt - a0), 32'd10);
        expect_res("t6", 4, 10, 0);
        consume("t6_drop");
        a0 = acc_cnt;
        vif.lbl_valid = 1'b1;
        vif.lbl       = 4'd4;
        tick();
        tick();
        vif.lbl_valid = 1'b0;
        check("t6_idle_no_accept", 32'(acc_cnt - a0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
